// File: rtl/hex_scan_arbiter_if.sv
// Request/display bus shared between the requesters and the hex scan arbiter.
interface hex_scan_arbiter_if;
  logic [3:0]  req;
  logic [63:0] data;
  logic [3:0]  grant;
  logic        busy;
  logic [3:0]  nibble;
  logic [3:0]  dig_n;

  modport master (output req, data, input grant, busy, nibble, dig_n);
  modport slave  (input req, data, output grant, busy, nibble, dig_n);
endinterface

// File: rtl/hex_scan_arbiter.sv
// Round-robin owner of a shared hex decoder and 4-digit common-anode display;
// the owner keeps the display for DWELL cycles while its value is scanned out.
module hex_scan_arbiter #(
  parameter int DWELL    = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input logic               CLOCK_50,
  input logic               KEY0,
  hex_scan_arbiter_if.slave bus
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_rr_ptr, w_rr_ptr_nxt;
  logic [DW-1:0] r_dwell_cnt, w_dwell_nxt;
  logic [SW-1:0] r_scan_cnt, w_scan_nxt;
  logic [1:0]    r_idx, w_idx_nxt;
  logic [15:0]   r_shadow, w_shadow_nxt;
  logic [3:0]    r_grant, w_grant_nxt;
  logic          r_busy, w_busy_nxt;
  logic [3:0]    r_nibble, w_nibble_nxt;
  logic [3:0]    r_dig_n, w_dig_n_nxt;
  logic          w_found;
  logic [1:0]    w_winner;

  // Round-robin search starting just after the last owner.
  always_comb begin
    w_found  = 1'b0;
    w_winner = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      if (!w_found && bus.req[r_rr_ptr + 2'(k)]) begin
        w_found  = 1'b1;
        w_winner = r_rr_ptr + 2'(k);
      end else begin
        w_found  = w_found;
      end
    end
  end

  // Next-state logic: arbitration, dwell timing, scanning and display.
  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_dwell_nxt  = r_dwell_cnt;
    w_shadow_nxt = r_shadow;
    w_grant_nxt  = r_grant;
    w_busy_nxt   = r_busy;
    w_scan_nxt   = r_scan_cnt + SW'(1);
    w_idx_nxt    = r_idx;
    w_nibble_nxt = 4'h0;
    w_dig_n_nxt  = 4'b1111;

    if (r_scan_cnt == SCAN_MAX) begin
      w_scan_nxt = '0;
      w_idx_nxt  = r_idx + 2'd1;
    end else begin
      w_idx_nxt  = r_idx;
    end

    // Display reads the current shadow, so a new grant appears one edge late.
    if (r_state == HOLD) begin
      w_nibble_nxt = r_shadow[{r_idx, 2'b00} +: 4];
      w_dig_n_nxt  = ~(4'b0001 << r_idx);
    end else begin
      w_nibble_nxt = 4'h0;
      w_dig_n_nxt  = 4'b1111;
    end

    case (r_state)
      IDLE, HOLD: begin
        if (r_state == HOLD && r_dwell_cnt != '0) begin
          w_dwell_nxt = r_dwell_cnt - DW'(1);
        end else if (w_found) begin
          w_state_nxt  = HOLD;
          w_rr_ptr_nxt = w_winner;
          w_dwell_nxt  = DWELL_MAX;
          w_shadow_nxt = bus.data[{w_winner, 4'b0000} +: 16];
          w_grant_nxt  = 4'b0001 << w_winner;
          w_busy_nxt   = 1'b1;
        end else begin
          w_state_nxt  = IDLE;
          w_grant_nxt  = 4'b0000;
          w_busy_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = 4'b0000;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      r_state     <= IDLE;
      r_rr_ptr    <= 2'd3;
      r_dwell_cnt <= '0;
      r_scan_cnt  <= '0;
      r_idx       <= 2'd0;
      r_shadow    <= 16'h0000;
      r_grant     <= 4'b0000;
      r_busy      <= 1'b0;
      r_nibble    <= 4'h0;
      r_dig_n     <= 4'b1111;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_dwell_cnt <= w_dwell_nxt;
      r_scan_cnt  <= w_scan_nxt;
      r_idx       <= w_idx_nxt;
      r_shadow    <= w_shadow_nxt;
      r_grant     <= w_grant_nxt;
      r_busy      <= w_busy_nxt;
      r_nibble    <= w_nibble_nxt;
      r_dig_n     <= w_dig_n_nxt;
    end
  end

  assign bus.grant  = r_grant;
  assign bus.busy   = r_busy;
  assign bus.nibble = r_nibble;
  assign bus.dig_n  = r_dig_n;

endmodule

// File: tb/tb_hex_scan_arbiter.sv
// Directed bench for hex_scan_arbiter: a cycle model feeds a scoreboard queue,
// and directed constant checks cover the listed scenarios.
module tb_hex_scan_arbiter;
  localparam int DWELL    = 8;
  localparam int SCAN_DIV = 2;

  logic clk  = 1'b0;
  logic KEY0 = 1'b1;

  hex_scan_arbiter_if u_if();

  hex_scan_arbiter #(.DWELL(DWELL), .SCAN_DIV(SCAN_DIV)) dut (
    .CLOCK_50 (clk),
    .KEY0     (KEY0),
    .bus      (u_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] g;
    logic       b;
    logic [3:0] n;
    logic [3:0] d;
  } obs_t;
  obs_t sb[$];

  logic        m_hold;
  int          m_ptr, m_dwell, m_div, m_idx;
  logic [15:0] m_shadow;
  logic [3:0]  m_grant, m_nib, m_dig;
  logic        m_busy;

  function automatic int pick(input logic [3:0] r, input int ptr);
    int w = -1;
    for (int k = 1; k <= 4; k++)
      if (w < 0 && r[(ptr + k) % 4]) w = (ptr + k) % 4;
    return w;
  endfunction

  always @(posedge clk or negedge KEY0) begin
    if (!KEY0) begin
      m_hold <= 1'b0; m_ptr <= 3; m_dwell <= 0; m_div <= 0; m_idx <= 0;
      m_shadow <= 16'h0; m_grant <= 4'h0; m_busy <= 1'b0; m_nib <= 4'h0; m_dig <= 4'hF;
    end else begin
      m_nib <= m_hold ? m_shadow[m_idx*4 +: 4] : 4'h0;
      m_dig <= m_hold ? ~(4'b0001 << m_idx) : 4'hF;
      m_div <= (m_div == SCAN_DIV - 1) ? 0 : m_div + 1;
      m_idx <= (m_div == SCAN_DIV - 1) ? (m_idx + 1) % 4 : m_idx;
      if (m_hold && m_dwell != 0) begin
        m_dwell <= m_dwell - 1;
      end else if (pick(u_if.req, m_ptr) >= 0) begin
        m_hold   <= 1'b1;
        m_busy   <= 1'b1;
        m_ptr    <= pick(u_if.req, m_ptr);
        m_grant  <= 4'b0001 << pick(u_if.req, m_ptr);
        m_shadow <= u_if.data[16*pick(u_if.req, m_ptr) +: 16];
        m_dwell  <= DWELL - 1;
      end else begin
        m_hold <= 1'b0; m_busy <= 1'b0; m_grant <= 4'h0;
      end
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h, wanted %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    obs_t e;
    @(posedge clk); #1;
    sb.push_back({m_grant, m_busy, m_nib, m_dig});
    @(negedge clk);
    e = sb.pop_front();
    check("model", 16'({u_if.grant, u_if.busy, u_if.nibble, u_if.dig_n}), 16'(e));
  endtask

  task automatic chk_digit(input string tag, input logic [15:0] v);
    int k = -1;
    for (int i = 0; i < 4; i++) if (u_if.dig_n == ~(4'b0001 << i)) k = i;
    check({tag, "_onecold"}, 16'(k >= 0), 16'd1);
    if (k >= 0) check(tag, 16'(u_if.nibble), 16'(v[4*k +: 4]));
  endtask

  task automatic do_reset();
    @(negedge clk);
    KEY0 = 1'b0;
    #2;
    sb.delete();
    check("rst_grant", 16'(u_if.grant), 16'h0);
    check("rst_busy", 16'(u_if.busy), 16'h0);
    check("rst_nibble", 16'(u_if.nibble), 16'h0);
    check("rst_dig_n", 16'(u_if.dig_n), 16'hF);
    @(negedge clk);
    KEY0 = 1'b1;
  endtask

  initial begin
    logic [3:0] exp_g [5];
    logic [3:0] prev;
    int seen, run, nb;
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    u_if.req  = 4'h0;
    u_if.data = 64'h0;
    #2 KEY0 = 1'b0;
    #2;
    check("rst0_grant", 16'(u_if.grant), 16'h0);
    check("rst0_dig_n", 16'(u_if.dig_n), 16'hF);
    @(negedge clk);
    KEY0 = 1'b1;

    for (int i = 0; i < 20; i++) begin
      cyc();
      check("idle_grant", 16'(u_if.grant), 16'h0);
      check("idle_dig_n", 16'(u_if.dig_n), 16'hF);
      check("idle_nibble", 16'(u_if.nibble), 16'h0);
    end

    u_if.data[31:16] = 16'hBEEF;
    u_if.req = 4'b0010;
    cyc();
    check("single_grant", 16'(u_if.grant), 16'h2);
    for (int i = 0; i < 24; i++) begin
      cyc();
      chk_digit("beef", 16'hBEEF);
      check("single_hold", 16'(u_if.grant), 16'h2);
    end

    do_reset();
    u_if.data = 64'h4444_3333_2222_1111;
    u_if.req  = 4'b1111;
    prev = 4'h0; seen = 0; run = 0;
    for (int i = 0; i < 36; i++) begin
      cyc();
      if (u_if.grant != prev) begin
        if (prev != 4'h0) check("rr_run", 16'(run), 16'(DWELL));
        if (seen < 5) check("rr_order", 16'(u_if.grant), 16'(exp_g[seen]));
        seen++;
        run = 0;
      end
      if (seen > 1) check("rr_no_gap", 16'(u_if.busy), 16'h1);
      prev = u_if.grant;
      run++;
    end
    check("rr_count", 16'(seen), 16'd5);

    do_reset();
    u_if.req = 4'b0001;
    cyc();
    u_if.req = 4'b0000;
    nb = (u_if.busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < 11; i++) begin
      cyc();
      if (u_if.busy === 1'b1) nb++;
    end
    check("minhold_busy", 16'(nb), 16'(DWELL));
    check("minhold_grant", 16'(u_if.grant), 16'h0);
    check("minhold_dig_n", 16'(u_if.dig_n), 16'hF);

    do_reset();
    u_if.data[15:0] = 16'h1234;
    u_if.req = 4'b0001;
    cyc();
    check("frz_busy", 16'(u_if.busy), 16'h1);
    u_if.data[15:0] = 16'h5678;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk_digit("frz_old", 16'h1234);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk_digit("frz_new", 16'h5678);
    end

    #2 KEY0 = 1'b0;
    #1;
    sb.delete();
    check("async_grant", 16'(u_if.grant), 16'h0);
    check("async_dig_n", 16'(u_if.dig_n), 16'hF);
    check("async_busy", 16'(u_if.busy), 16'h0);
    @(negedge clk);
    KEY0 = 1'b1;
    u_if.req = 4'b1000;
    cyc();
    check("after_rst_grant", 16'(u_if.grant), 16'h8);
    for (int i = 0; i < 4; i++) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hex_scan_arbiter.md
Name: hex_scan_arbiter

Overview:
- Shares one hex-to-7-segment decoder and a 4-digit common-anode display among 4 requesters.
- Arbitrates requesters round-robin and holds each grant for a minimum dwell time.
- During a grant, time-multiplexes the granted 16-bit value one nibble per digit.
- The nibble output feeds the existing decoder's 4-bit input; dig_n drives the digit enables.

Parameters:
- DWELL, 50_000_000, grant hold time in clock cycles; legal range >= 1.
- SCAN_DIV, 50_000, clock cycles per digit step; legal range >= 1; 1 means step every cycle.

Ports:
- CLOCK_50  input  1  system clock; all state changes on the rising edge.
- KEY0  input  1  asynchronous active-low reset.
- req  input  4  request lines; bit i = requester i, level-sensitive.
- data  input  64  requester values; data[16*i+15:16*i] belongs to requester i.
- grant  output  4  one-hot current owner; all zero when idle; registered.
- busy  output  1  high while in HOLD; registered.
- nibble  output  4  hex digit for the shared decoder; registered.
- dig_n  output  4  active-low digit enables; bit k selects digit k; registered.

Behaviour:
- Reset (KEY0 low, takes effect immediately, independent of clock):
  - Outputs: grant=0, busy=0, nibble=0, dig_n=4'b1111.
  - Internal state: state=IDLE, rr_ptr=3 (so the first grant goes to requester 0), dwell_cnt=0, scan_div_cnt=0, digit index idx=0, shadow=0.
- FSM states: IDLE, HOLD.
- IDLE, req==0: remain in IDLE; outputs stay blanked (dig_n=1111, nibble=0).
- IDLE, req!=0, at edge t:
  - Winner = first set bit searching rr_ptr+1, rr_ptr+2, ... modulo 4.
  - shadow <= data slice of the winner; grant <= one-hot of winner; rr_ptr <= winner; busy <= 1.
  - dwell_cnt <= DWELL-1; state <= HOLD.
  - All these outputs are visible after edge t (one-cycle latency).
- HOLD, dwell_cnt != 0: decrement dwell_cnt.
  - shadow is frozen; later data changes are not shown until the next grant.
  - The owner dropping req mid-hold has no effect; the minimum hold is guaranteed.
- HOLD, dwell_cnt == 0 (expiry): apply the IDLE arbitration from rr_ptr+1.
  - If another requester wins, grant switches in the same edge, with no IDLE gap.
  - If only the owner requests, it is re-granted: fresh shadow, dwell reloaded.
  - If req==0: state <= IDLE; grant <= 0; busy <= 0.
- Scanner (runs in both states):
  - scan_div_cnt counts 0..SCAN_DIV-1, then wraps to 0.
  - idx advances by 1 on each wrap (0,1,2,3,0, ...).
  - idx is not reset on a new grant.
- Registered display outputs:
  - In HOLD: nibble <= shadow[4*idx+3:4*idx]; dig_n <= ~(4'b0001 << idx).
  - In IDLE: nibble <= 0; dig_n <= 1111.
  - Exactly one dig_n bit is low in HOLD; none is low in IDLE.
- Display output update rules:
  - On a grant edge, display outputs use the new shadow from the next edge.
  - On the cycle of the grant edge itself they still show the blank or previous-owner value.
  - This one-cycle skew is accepted and must be matched exactly by the model.
- Simultaneous events:
  - Several requests in the same cycle: round-robin order decides.
  - Dwell expiry coinciding with a scan step: both take effect on the same edge.
- Fairness: any continuously held request is granted within 3 dwell periods.
- Reset asserted mid-HOLD: immediate blanking and rr_ptr=3, regardless of clock.
- Counter widths: $clog2 of the parameter, minimum 1 bit. Counters never exceed parameter-1.

Test Plan (DWELL=8, SCAN_DIV=2):
- Reset then idle:
  - Stimulus: KEY0 low, release, req=0 for 20 cycles.
  - Response: grant=0, busy=0, dig_n=1111, nibble=0 throughout.
- Single requester:
  - Stimulus: req=0010, data[31:16]=16'hBEEF.
  - Response: grant=0010 one cycle later.
  - Response: nibble cycles F,E,E,B with dig_n 1110,1101,1011,0111, each held 2 cycles.
  - Response: re-grant every 8 cycles while req is held.
- Round-robin contention:
  - Stimulus: req=1111 held.
  - Response: grant sequence 0001,0010,0100,1000,0001, each held exactly 8 cycles, with no IDLE gap.
- Minimum hold:
  - Stimulus: req=0001 for 1 cycle only.
  - Response: busy high for exactly 8 cycles, then IDLE and blanked.
- Frozen shadow:
  - Stimulus: data[15:0] changes 1234 -> 5678 during requester 0's hold, with req=0001 held.
  - Response: digits show 1234 until expiry, then 5678 after the re-grant.
- Async reset mid-hold:
  - Stimulus: KEY0 low mid-cycle in HOLD.
  - Response: dig_n=1111 and grant=0 immediately, without waiting for a clock edge.
  - Response: after release with req=1000, first grant goes to requester 3.
